// File: rtl/jtag_tap_responder.sv
// JTAG TAP responder running entirely in the pclk domain: TCK/TMS/TDI/TRSTn are
// oversampled, and the IR, BYPASS, IDCODE and a 32-bit user DR are served from them.
module jtag_tap_responder #(
  parameter int                  IR_WIDTH    = 5,
  parameter logic [31:0]         IDCODE_VAL  = 32'h1000_0DB3,
  parameter logic [IR_WIDTH-1:0] IDCODE_IR   = IR_WIDTH'(5'h01),
  parameter logic [IR_WIDTH-1:0] USER_IR     = IR_WIDTH'(5'h10),
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                pclk_i,
  input  logic                prst_i,
  input  logic                tck_i,
  input  logic                tms_i,
  input  logic                tdi_i,
  input  logic                trstn_i,
  output logic                tdo_o,
  output logic                tdo_oe_o,
  output logic [3:0]          tap_state_o,
  output logic [IR_WIDTH-1:0] ir_o,
  input  logic [31:0]         user_capture_i,
  output logic [31:0]         user_dr_o,
  output logic                user_update_o
);

  typedef enum logic [3:0] {
    TLR      = 4'hF, RTI      = 4'hC, SEL_DR   = 4'h7, CAP_DR   = 4'h6,
    SH_DR    = 4'h2, EX1_DR   = 4'h1, PAUSE_DR = 4'h3, EX2_DR   = 4'h0,
    UPD_DR   = 4'h5, SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR    = 4'hA,
    EX1_IR   = 4'h9, PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR   = 4'hD
  } tap_state_e;

  function automatic tap_state_e tap_next(input tap_state_e st, input logic tms);
    case (st)
      TLR:      tap_next = tms ? TLR      : RTI;
      RTI:      tap_next = tms ? SEL_DR   : RTI;
      SEL_DR:   tap_next = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   tap_next = tms ? EX1_DR   : SH_DR;
      SH_DR:    tap_next = tms ? EX1_DR   : SH_DR;
      EX1_DR:   tap_next = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: tap_next = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   tap_next = tms ? UPD_DR   : SH_DR;
      UPD_DR:   tap_next = tms ? SEL_DR   : RTI;
      SEL_IR:   tap_next = tms ? TLR      : CAP_IR;
      CAP_IR:   tap_next = tms ? EX1_IR   : SH_IR;
      SH_IR:    tap_next = tms ? EX1_IR   : SH_IR;
      EX1_IR:   tap_next = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: tap_next = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   tap_next = tms ? UPD_IR   : SH_IR;
      UPD_IR:   tap_next = tms ? SEL_DR   : RTI;
      default:  tap_next = TLR;
    endcase
  endfunction

  // Bit order in each synchroniser stage: {trstn, tdi, tms, tck}.
  logic [3:0]          sync_q [SYNC_STAGES];
  logic                tck_dly_q;
  logic                tck_s, tms_s, tdi_s, trstn_s, rise_s, fall_s;
  logic                user_sel_s, idcode_sel_s;
  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_shift_q;
  logic [31:0]         dr_shift_q, user_dr_q;
  logic                bypass_q, tdo_q, tdo_oe_q, user_update_q;

  // Pin synchroniser chain plus the delayed TCK used for edge detection.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b1000;
      tck_dly_q <= 1'b0;
    end else begin
      sync_q[0] <= {trstn_i, tdi_i, tms_i, tck_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      tck_dly_q <= sync_q[SYNC_STAGES-1][0];
    end
  end

  // Edge detect, opcode decode and next TAP state.
  always_comb begin
    tck_s        = sync_q[SYNC_STAGES-1][0];
    tms_s        = sync_q[SYNC_STAGES-1][1];
    tdi_s        = sync_q[SYNC_STAGES-1][2];
    trstn_s      = sync_q[SYNC_STAGES-1][3];
    rise_s       = tck_s & ~tck_dly_q;
    fall_s       = ~tck_s & tck_dly_q;
    user_sel_s   = (ir_q == USER_IR);
    idcode_sel_s = (ir_q == IDCODE_IR);
    state_d      = tap_next(state_q, tms_s);
  end

  // TAP controller: state, shift paths, TDO and update registers.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q       <= TLR;
      ir_q          <= IDCODE_IR;
      ir_shift_q    <= '0;
      dr_shift_q    <= 32'h0000_0000;
      bypass_q      <= 1'b0;
      tdo_q         <= 1'b0;
      tdo_oe_q      <= 1'b0;
      user_dr_q     <= 32'h0000_0000;
      user_update_q <= 1'b0;
    end else begin
      user_update_q <= 1'b0;
      if (state_q == TLR) ir_q <= IDCODE_IR;
      if (!trstn_s) begin
        state_q  <= TLR;
        ir_q     <= IDCODE_IR;
        tdo_q    <= 1'b0;
        tdo_oe_q <= 1'b0;
      end else if (rise_s) begin
        case (state_q)
          CAP_IR: ir_shift_q <= IR_WIDTH'(2'b01);
          SH_IR:  ir_shift_q <= {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
          CAP_DR: begin
            if (idcode_sel_s)    dr_shift_q <= IDCODE_VAL;
            else if (user_sel_s) dr_shift_q <= user_capture_i;
            else                 bypass_q   <= 1'b0;
          end
          SH_DR: begin
            if (idcode_sel_s || user_sel_s) dr_shift_q <= {tdi_s, dr_shift_q[31:1]};
            else                            bypass_q   <= tdi_s;
          end
          default: ;
        endcase
        state_q <= state_d;
      end else if (fall_s) begin
        if (state_q == SH_IR) begin
          tdo_q    <= ir_shift_q[0];
          tdo_oe_q <= 1'b1;
        end else if (state_q == SH_DR) begin
          tdo_q    <= (idcode_sel_s || user_sel_s) ? dr_shift_q[0] : bypass_q;
          tdo_oe_q <= 1'b1;
        end else begin
          tdo_q    <= 1'b0;
          tdo_oe_q <= 1'b0;
        end
        if (state_q == UPD_IR) ir_q <= ir_shift_q;
        if (state_q == UPD_DR && user_sel_s) begin
          user_dr_q     <= dr_shift_q;
          user_update_q <= 1'b1;
        end
      end
    end
  end

  assign tdo_o         = tdo_q;
  assign tdo_oe_o      = tdo_oe_q;
  assign tap_state_o   = state_q;
  assign ir_o          = ir_q;
  assign user_dr_o     = user_dr_q;
  assign user_update_o = user_update_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: bit-bangs TCK slowly relative to pclk
// and checks state codes, TDO streams, IR/DR updates and reset behaviour.
module tb_jtag_tap_responder;

  logic        pclk_i = 1'b0;
  logic        prst_i, tck_i, tms_i, tdi_i, trstn_i;
  logic        tdo_o, tdo_oe_o, user_update_o;
  logic [3:0]  tap_state_o;
  logic [4:0]  ir_o;
  logic [31:0] user_capture_i, user_dr_o;

  int n_cmp = 0;
  int n_err = 0;
  int n_upd = 0;

  logic        b_s, oe_s;
  logic [4:0]  ir_out_s;
  logic [31:0] dr_out_s;

  jtag_tap_responder dut (
    .pclk_i(pclk_i), .prst_i(prst_i), .tck_i(tck_i), .tms_i(tms_i),
    .tdi_i(tdi_i), .trstn_i(trstn_i), .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o),
    .tap_state_o(tap_state_o), .ir_o(ir_o), .user_capture_i(user_capture_i),
    .user_dr_o(user_dr_o), .user_update_o(user_update_o)
  );

  always #5 pclk_i = ~pclk_i;

  // Count pclk cycles with the update strobe high; one pulse of width 1 adds 1.
  always @(negedge pclk_i) if (user_update_o === 1'b1) n_upd++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One TCK period; tdo/oe are sampled just before the rising edge.
  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo, output logic oe);
    @(negedge pclk_i);
    tdo   = tdo_o;
    oe    = tdo_oe_o;
    tms_i = tms;
    tdi_i = tdi;
    @(negedge pclk_i);
    tck_i = 1'b1;
    repeat (6) @(negedge pclk_i);
    tck_i = 1'b0;
    repeat (6) @(negedge pclk_i);
  endtask

  task automatic scan_ir(input logic [4:0] v, output logic [4:0] dout);
    logic b, oe;
    dout = 5'h00;
    tck_cycle(1'b1, 1'b0, b, oe);
    tck_cycle(1'b1, 1'b0, b, oe);
    tck_cycle(1'b0, 1'b0, b, oe);
    tck_cycle(1'b0, 1'b0, b, oe);
    check("ir_state_shir", {28'h0, tap_state_o}, 32'hA);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, v[i], b, oe);
      dout[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b, oe);
    tck_cycle(1'b0, 1'b0, b, oe);
    check("ir_state_rti", {28'h0, tap_state_o}, 32'hC);
  endtask

  task automatic scan_dr(input logic [31:0] din, input int len, output logic [31:0] dout);
    logic b, oe;
    dout = 32'h0000_0000;
    tck_cycle(1'b1, 1'b0, b, oe);
    check("dr_state_seldr", {28'h0, tap_state_o}, 32'h7);
    tck_cycle(1'b0, 1'b0, b, oe);
    check("dr_state_capdr", {28'h0, tap_state_o}, 32'h6);
    tck_cycle(1'b0, 1'b0, b, oe);
    check("dr_state_shdr", {28'h0, tap_state_o}, 32'h2);
    check("dr_oe_before_shift", {31'h0, oe}, 32'h0);
    for (int i = 0; i < len; i++) begin
      tck_cycle(i == len - 1, din[i], b, oe);
      dout[i] = b;
      check("dr_oe_shift", {31'h0, oe}, 32'h1);
    end
    check("dr_state_ex1", {28'h0, tap_state_o}, 32'h1);
    tck_cycle(1'b1, 1'b0, b, oe);
    check("dr_oe_after_shift", {31'h0, oe}, 32'h0);
    check("dr_state_upd", {28'h0, tap_state_o}, 32'h5);
    tck_cycle(1'b0, 1'b0, b, oe);
    check("dr_state_rti", {28'h0, tap_state_o}, 32'hC);
  endtask

  initial begin
    prst_i         = 1'b1;
    tck_i          = 1'b0;
    tms_i          = 1'b1;
    tdi_i          = 1'b0;
    trstn_i        = 1'b1;
    user_capture_i = 32'h0000_0000;
    repeat (3) @(negedge pclk_i);
    check("rst_state", {28'h0, tap_state_o}, 32'hF);
    check("rst_ir", {27'h0, ir_o}, 32'h01);
    check("rst_tdo", {31'h0, tdo_o}, 32'h0);
    check("rst_oe", {31'h0, tdo_oe_o}, 32'h0);
    check("rst_user_dr", user_dr_o, 32'h0);
    check("rst_update", {31'h0, user_update_o}, 32'h0);
    prst_i = 1'b0;
    repeat (2) @(negedge pclk_i);

    // Five TMS=1 clocks land in TLR, then TMS=0 moves to RTI.
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, b_s, oe_s);
    check("tlr_state", {28'h0, tap_state_o}, 32'hF);
    tck_cycle(1'b0, 1'b0, b_s, oe_s);
    check("rti_state", {28'h0, tap_state_o}, 32'hC);
    check("rti_ir", {27'h0, ir_o}, 32'h01);
    check("rti_oe", {31'h0, tdo_oe_o}, 32'h0);

    scan_dr(32'h0000_0000, 32, dr_out_s);
    check("idcode_tdo", dr_out_s, 32'h1000_0DB3);

    // Select the user DR; IR capture shifts out 1,0,0,0,0.
    scan_ir(5'h10, ir_out_s);
    check("ir_cap_bit0", {31'h0, ir_out_s[0]}, 32'h1);
    check("ir_cap_bit1", {31'h0, ir_out_s[1]}, 32'h0);
    check("ir_cap_all", {27'h0, ir_out_s}, 32'h01);
    check("ir_user", {27'h0, ir_o}, 32'h10);
    scan_dr(32'hA5A5_5A5A, 32, dr_out_s);
    check("user_cap_zero", dr_out_s, 32'h0000_0000);
    check("user_dr_a5", user_dr_o, 32'hA5A5_5A5A);
    check("upd_count_1", n_upd, 32'd1);

    user_capture_i = 32'hDEAD_BEEF;
    scan_dr(32'h0000_0000, 32, dr_out_s);
    check("user_cap_beef", dr_out_s, 32'hDEAD_BEEF);
    check("user_dr_zero", user_dr_o, 32'h0000_0000);
    check("upd_count_2", n_upd, 32'd2);

    // All-ones opcode selects BYPASS: one-bit delay, captured 0 first.
    scan_ir(5'h1F, ir_out_s);
    check("ir_bypass", {27'h0, ir_o}, 32'h1F);
    scan_dr(32'h0000_000D, 4, dr_out_s);
    check("bypass_tdo", dr_out_s, 32'h0000_000A);
    check("upd_count_bypass", n_upd, 32'd2);

    scan_ir(5'h10, ir_out_s);
    scan_dr(32'h1234_5678, 32, dr_out_s);
    check("user_dr_1234", user_dr_o, 32'h1234_5678);
    check("upd_count_3", n_upd, 32'd3);

    // TRSTn pulse in the middle of a DR shift.
    tck_cycle(1'b1, 1'b0, b_s, oe_s);
    tck_cycle(1'b0, 1'b0, b_s, oe_s);
    tck_cycle(1'b0, 1'b0, b_s, oe_s);
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, b_s, oe_s);
    check("trst_pre_state", {28'h0, tap_state_o}, 32'h2);
    check("trst_pre_oe", {31'h0, tdo_oe_o}, 32'h1);
    trstn_i = 1'b0;
    repeat (2) @(negedge pclk_i);
    trstn_i = 1'b1;
    repeat (4) @(negedge pclk_i);
    check("trst_state", {28'h0, tap_state_o}, 32'hF);
    check("trst_ir", {27'h0, ir_o}, 32'h01);
    check("trst_oe", {31'h0, tdo_oe_o}, 32'h0);
    check("trst_user_dr", user_dr_o, 32'h1234_5678);
    check("trst_upd_count", n_upd, 32'd3);
    tck_cycle(1'b0, 1'b0, b_s, oe_s);
    check("trst_rti", {28'h0, tap_state_o}, 32'hC);

    // Same abort, this time with the synchronous reset.
    scan_ir(5'h10, ir_out_s);
    tck_cycle(1'b1, 1'b0, b_s, oe_s);
    tck_cycle(1'b0, 1'b0, b_s, oe_s);
    tck_cycle(1'b0, 1'b0, b_s, oe_s);
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, b_s, oe_s);
    check("prst_pre_state", {28'h0, tap_state_o}, 32'h2);
    prst_i = 1'b1;
    @(negedge pclk_i);
    prst_i = 1'b0;
    check("prst_state", {28'h0, tap_state_o}, 32'hF);
    check("prst_ir", {27'h0, ir_o}, 32'h01);
    check("prst_oe", {31'h0, tdo_oe_o}, 32'h0);
    check("prst_user_dr", user_dr_o, 32'h0000_0000);
    repeat (4) @(negedge pclk_i);
    check("prst_upd_count", n_upd, 32'd3);
    check("prst_state_hold", {28'h0, tap_state_o}, 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_tap_responder.md
Name: jtag_tap_responder

Overview:
- JTAG target: an IEEE 1149.1-style TAP controller with IR, BYPASS, IDCODE and one 32-bit user data register.
- Runs entirely in the pclk domain; TCK/TMS/TDI/TRSTn are oversampled and synchronised, not used as clocks.
- Acts as the far-end responder for the team's APB JTAG driver in DV benches and subsystem loopback tests.
- Exposes the TAP state and user register contents to the fabric.

Parameters:
- IR_WIDTH, 5, instruction register width (≥2).
- IDCODE_VAL, 32'h1000_0DB3, value captured by IDCODE (bit0 must be 1).
- IDCODE_IR, 5'h01, IDCODE opcode; loaded into IR in Test-Logic-Reset.
- USER_IR, 5'h10, opcode selecting the user DR.
- SYNC_STAGES, 2, synchroniser depth on tck_i/tms_i/tdi_i/trstn_i.

Ports:
- pclk_i  in  1  system clock.
- prst_i  in  1  synchronous active-high reset.
- tck_i  in  1  JTAG TCK; asynchronous to pclk_i.
- tms_i  in  1  JTAG TMS.
- tdi_i  in  1  JTAG TDI (driver's TDO).
- trstn_i  in  1  JTAG TRSTn, active low.
- tdo_o  out  1  JTAG TDO (driver's TDI).
- tdo_oe_o  out  1  TDO output enable.
- tap_state_o  out  4  current TAP state code.
- ir_o  out  IR_WIDTH  active instruction.
- user_capture_i  in  32  value loaded into the user DR shift register in Capture-DR.
- user_dr_o  out  32  user DR update register.
- user_update_o  out  1  one-pclk pulse when user_dr_o is written.

Behaviour:
- Reset (prst_i=1 at a pclk edge) sets: state Test-Logic-Reset (TLR, 4'hF), ir_o=IDCODE_IR, tdo_o=0, tdo_oe_o=0, user_dr_o=0, user_update_o=0, shift registers=0, synchroniser flops=0 except trstn=1.
- Reset applied mid-shift discards the shift in progress; no update pulse is produced.
- Sampling: inputs pass SYNC_STAGES flops, then one more flop on the synchronised TCK for edge detect.
  - rise = synced & ~delayed; fall = ~synced & delayed.
  - Latency from TCK pin edge to action is SYNC_STAGES+1 pclk.
  - TCK high and low must each last ≥ SYNC_STAGES+2 pclk; shorter pulses are unsupported.
- TRSTn: synced trstn=0 forces TLR and ir_o=IDCODE_IR every cycle, overriding any edge. tdo_oe_o=0 while it is asserted.
- State codes: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- Transitions occur on rise, using synced TMS, per the standard 1149.1 TAP graph.
- Actions on rise, based on the current state before the transition:
  - CapIR: ir_shift <= {0…,2'b01}.
  - ShIR: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}.
  - CapDR: selected DR loads its capture value: IDCODE_VAL for IDCODE, user_capture_i for USER_IR, 0 for BYPASS.
  - ShDR: selected DR shifts right, tdi entering the MSB. DR length is 32 for IDCODE/USER and 1 for BYPASS.
- Actions on fall:
  - In ShIR/ShDR: tdo_o <= LSB of the active shift register and tdo_oe_o <= 1.
  - In any other state: tdo_oe_o <= 0 and tdo_o <= 0.
  - In UpdIR: ir_o <= ir_shift.
  - In UpdDR with ir_o==USER_IR: user_dr_o <= dr_shift and user_update_o=1 for exactly that pclk.
- Opcode decode: any opcode other than IDCODE_IR or USER_IR, including all-ones, selects BYPASS.
- Bit order is LSB-first in and out, matching the driver's shift order.
- Five consecutive rises with TMS=1 reach TLR from any state.
- Simultaneous rise and fall in the same pclk cannot occur; prst_i has priority over trstn, and trstn has priority over edges.

Test Plan:
- Reset, then 5 TCK with TMS=1, then TMS=0 -> tap_state_o walks to F, then C; ir_o=5'h01; tdo_oe_o=0.
- From RTI, go to ShDR and shift 32 bits of TDI=0 -> TDO stream LSB-first equals 32'h1000_0DB3; tdo_oe_o=1 only during ShDR.
- Shift IR=5'h10 and observe the first 2 TDO bits -> 1,0 (capture 2'b01). Then DR-shift 32'hA5A5_5A5A and Update -> user_dr_o=32'hA5A5_5A5A with a single-cycle user_update_o.
- user_capture_i=32'hDEAD_BEEF, DR scan with TDI=0 -> TDO reads 32'hDEAD_BEEF; user_dr_o becomes 0 after update.
- IR=5'h1F (BYPASS), shift TDI pattern 1,0,1,1 -> TDO shows 0,1,0,1 (one-bit delay, captured 0 first).
- trstn_i low for 2 pclk (after synchroniser) mid-ShDR -> state F and ir_o=5'h01 immediately, no user_update_o. Repeating the test with prst_i pulsed instead gives the same result.
